fwd_source_pipe: RTL and testbench

//  Producer side of the decode-stage bypass network: holds the EX/MEM and MEM/WB result slots.

---
 rtl/fwd_pkg.sv | 32 +++
 rtl/fwd_source_pipe_if.sv | 48 ++++
 rtl/fwd_slot.sv | 30 +++
 rtl/fwd_source_pipe.sv | 182 ++++++++++++++++++
 tb/tb_fwd_source_pipe.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the decode-stage bypass producer: result slot layout,
// MEM-slot FSM encoding and the register-zero constant.
package fwd_pkg;

  localparam int FWD_ADDR_W = 6;
  localparam int FWD_DATA_W = 32;

  localparam logic [FWD_ADDR_W-1:0] REG_ZERO = {FWD_ADDR_W{1'b0}};

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_WAIT  = 2'd1,
    MEM_DRAIN = 2'd2
  } mem_state_e;

  // One pipeline result slot. 'ready' is low while a load still waits for data.
  typedef struct packed {
    logic                  valid;
    logic                  reg_en;
    logic                  is_load;
    logic                  ready;
    logic [FWD_ADDR_W-1:0] addr;
    logic [FWD_DATA_W-1:0] data;
  } fwd_slot_t;

  // True when a source register is non-zero and equals a destination register.
  function automatic logic addr_hit(input logic [FWD_ADDR_W-1:0] src,
                                    input logic [FWD_ADDR_W-1:0] dst);
    return (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/fwd_source_pipe_if.sv
// Bundle of the execute, memory-response, decode, forwarding and
// register-file signals around the bypass producer.
interface fwd_source_pipe_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);

  logic              flush;
  logic              ex_valid;
  logic              ex_reg_en;
  logic [ADDR_W-1:0] ex_reg_addr;
  logic [DATA_W-1:0] ex_reg_data;
  logic              ex_is_load;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] id_rs_addr;
  logic [ADDR_W-1:0] id_rt_addr;

  logic              fwd_ex_en;
  logic [ADDR_W-1:0] fwd_ex_addr;
  logic [DATA_W-1:0] fwd_ex_data;
  logic              fwd_mem_en;
  logic [ADDR_W-1:0] fwd_mem_addr;
  logic [DATA_W-1:0] fwd_mem_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              ex_hold;
  logic              load_use_stall;
  logic              protocol_err;

  // Surrounding pipeline side.
  modport master (
    output flush, ex_valid, ex_reg_en, ex_reg_addr, ex_reg_data, ex_is_load,
    output mem_rvalid, mem_rdata, id_rs_addr, id_rt_addr,
    input  fwd_ex_en, fwd_ex_addr, fwd_ex_data, fwd_mem_en, fwd_mem_addr, fwd_mem_data,
    input  rf_we, rf_waddr, rf_wdata, ex_hold, load_use_stall, protocol_err
  );

  // Bypass producer side.
  modport slave (
    input  flush, ex_valid, ex_reg_en, ex_reg_addr, ex_reg_data, ex_is_load,
    input  mem_rvalid, mem_rdata, id_rs_addr, id_rt_addr,
    output fwd_ex_en, fwd_ex_addr, fwd_ex_data, fwd_mem_en, fwd_mem_addr, fwd_mem_data,
    output rf_we, rf_waddr, rf_wdata, ex_hold, load_use_stall, protocol_err
  );

endinterface

// File: rtl/fwd_slot.sv
// One clocked result slot. Priority: reset, then kill, then load, else hold.
module fwd_slot
  import fwd_pkg::*;
(
  input  logic      clk,
  input  logic      resetn,
  input  logic      load_en,
  input  logic      kill,
  input  fwd_slot_t d,
  output fwd_slot_t q
);

  fwd_slot_t q_r;

  // Slot register: clear on reset or kill, capture on load, otherwise keep.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      q_r <= '0;
    end else if (kill) begin
      q_r <= '0;
    end else if (load_en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/fwd_source_pipe.sv
// Producer side of the decode-stage bypass network. Holds the EX/MEM and
// MEM/WB result slots, sequences multi-cycle loads in MEM, and drives the
// EX/MEM forwarding sources, the register-file write port and the load-use stall.
module fwd_source_pipe
  import fwd_pkg::*;
#(
  parameter int ADDR_W = FWD_ADDR_W,
  parameter int DATA_W = FWD_DATA_W
) (
  input  logic          clk,
  input  logic          resetn,
  fwd_source_pipe_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = MEM_IDLE;
  localparam logic [1:0] ST_WAIT  = MEM_WAIT;
  localparam logic [1:0] ST_DRAIN = MEM_DRAIN;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  fwd_slot_t         mem_q_s;
  fwd_slot_t         mem_d_s;
  logic              mem_load_s;
  logic              mem_kill_s;
  fwd_slot_t         wb_q_s;
  fwd_slot_t         wb_d_s;
  fwd_slot_t         ex_slot_s;
  logic              err_set_s;
  logic              protocol_err_r;
  logic              ex_load_s;
  logic              wait_dest_s;
  logic [ADDR_W-1:0] rs_s;
  logic [ADDR_W-1:0] rt_s;
  logic [DATA_W-1:0] ex_load_data_s;
  logic [1:0]        unused_wb_s;

  assign rs_s = bus.id_rs_addr;
  assign rt_s = bus.id_rt_addr;

  // EX source is a pure pass-through; loads never forward from EX.
  assign bus.fwd_ex_en   = bus.ex_valid & bus.ex_reg_en & ~bus.ex_is_load &
                           (bus.ex_reg_addr != REG_ZERO);
  assign bus.fwd_ex_addr = bus.ex_reg_addr;
  assign bus.fwd_ex_data = bus.ex_reg_data;

  // A load whose response arrives in the accept cycle is complete on entry.
  assign ex_load_data_s = bus.mem_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};

  // Candidate MEM-slot contents built from the EX stage (bubble when EX invalid).
  always_comb begin
    ex_slot_s = '0;
    if (bus.ex_valid) begin
      ex_slot_s.valid   = 1'b1;
      ex_slot_s.reg_en  = bus.ex_reg_en;
      ex_slot_s.is_load = bus.ex_is_load;
      ex_slot_s.ready   = ~bus.ex_is_load | bus.mem_rvalid;
      ex_slot_s.addr    = bus.ex_reg_addr;
      ex_slot_s.data    = bus.ex_is_load ? ex_load_data_s : bus.ex_reg_data;
    end else begin
      ex_slot_s = '0;
    end
  end

  // MEM-slot FSM: accept from EX in IDLE, wait for load data, drain a flushed load's response.
  always_comb begin
    state_nxt_s = state_r;
    mem_load_s  = 1'b0;
    mem_kill_s  = 1'b0;
    mem_d_s     = mem_q_s;
    err_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.flush) begin
          mem_kill_s  = 1'b1;
          err_set_s   = bus.mem_rvalid;
          state_nxt_s = ST_IDLE;
        end else begin
          mem_load_s = 1'b1;
          mem_d_s    = ex_slot_s;
          err_set_s  = bus.mem_rvalid & ~(bus.ex_valid & bus.ex_is_load);
          if (bus.ex_valid & bus.ex_is_load & ~bus.mem_rvalid) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          // Response consumed either way; a simultaneous flush kills the slot.
          if (bus.flush) begin
            mem_kill_s = 1'b1;
          end else begin
            mem_load_s    = 1'b1;
            mem_d_s.data  = bus.mem_rdata;
            mem_d_s.ready = 1'b1;
          end
          state_nxt_s = ST_IDLE;
        end else if (bus.flush) begin
          mem_kill_s  = 1'b1;
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        mem_kill_s = 1'b1;
        if (bus.mem_rvalid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        mem_kill_s  = 1'b1;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // MEM-slot state register and sticky protocol-error flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      protocol_err_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      protocol_err_r <= protocol_err_r | err_set_s;
    end
  end

  fwd_slot u_mem_slot (
    .clk     (clk),
    .resetn  (resetn),
    .load_en (mem_load_s),
    .kill    (mem_kill_s),
    .d       (mem_d_s),
    .q       (mem_q_s)
  );

  // WB takes only completed, unflushed MEM results; anything else becomes a bubble.
  always_comb begin
    wb_d_s = '0;
    if (mem_q_s.valid & mem_q_s.ready & ~bus.flush) begin
      wb_d_s = mem_q_s;
    end else begin
      wb_d_s = '0;
    end
  end

  fwd_slot u_wb_slot (
    .clk     (clk),
    .resetn  (resetn),
    .load_en (1'b1),
    .kill    (1'b0),
    .d       (wb_d_s),
    .q       (wb_q_s)
  );

  assign unused_wb_s = {wb_q_s.is_load, wb_q_s.ready};

  assign bus.fwd_mem_en   = mem_q_s.valid & mem_q_s.reg_en & mem_q_s.ready &
                            (mem_q_s.addr != REG_ZERO);
  assign bus.fwd_mem_addr = mem_q_s.addr;
  assign bus.fwd_mem_data = mem_q_s.data;

  assign bus.rf_we    = wb_q_s.valid & wb_q_s.reg_en & (wb_q_s.addr != REG_ZERO);
  assign bus.rf_waddr = wb_q_s.addr;
  assign bus.rf_wdata = wb_q_s.data;

  assign bus.ex_hold      = (state_r == ST_WAIT) | (state_r == ST_DRAIN);
  assign bus.protocol_err = protocol_err_r;

  // Load-use: a source produced by the EX load or by the load waiting in MEM.
  assign ex_load_s   = bus.ex_valid & bus.ex_is_load & bus.ex_reg_en;
  assign wait_dest_s = (state_r == ST_WAIT) & mem_q_s.valid & mem_q_s.reg_en;

  assign bus.load_use_stall =
      (ex_load_s   & (addr_hit(rs_s, bus.ex_reg_addr) | addr_hit(rt_s, bus.ex_reg_addr))) |
      (wait_dest_s & (addr_hit(rs_s, mem_q_s.addr)    | addr_hit(rt_s, mem_q_s.addr)));

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Directed bench for fwd_source_pipe: ALU chain, load-use, zero register,
// flush cases, protocol error and reset in WAIT, with hand-computed expectations.
module tb_fwd_source_pipe;

  logic clk;
  logic resetn;
  int   vec_cnt;
  int   err_cnt;

  fwd_source_pipe_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  fwd_source_pipe #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven 1 ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.flush       = 1'b0;
    bus.ex_valid    = 1'b0;
    bus.ex_reg_en   = 1'b0;
    bus.ex_reg_addr = 6'd0;
    bus.ex_reg_data = 32'd0;
    bus.ex_is_load  = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = 32'd0;
    bus.id_rs_addr  = 6'd0;
    bus.id_rt_addr  = 6'd0;
  endtask

  task automatic drive_ex(input logic is_load, input logic [5:0] addr, input logic [31:0] data);
    bus.ex_valid    = 1'b1;
    bus.ex_reg_en   = 1'b1;
    bus.ex_is_load  = is_load;
    bus.ex_reg_addr = addr;
    bus.ex_reg_data = data;
  endtask

  task automatic test_reset;
    idle_inputs();
    resetn = 1'b0;
    tick(); tick();
    #1;
    vec_cnt++; if (bus.fwd_mem_en !== 1'b0) begin err_cnt++; $display("FAIL rst_fwd_mem_en got %b want 0", bus.fwd_mem_en); end
    vec_cnt++; if (bus.fwd_mem_data !== 32'd0) begin err_cnt++; $display("FAIL rst_fwd_mem_data got %h want 0", bus.fwd_mem_data); end
    vec_cnt++; if (bus.rf_we !== 1'b0) begin err_cnt++; $display("FAIL rst_rf_we got %b want 0", bus.rf_we); end
    vec_cnt++; if (bus.ex_hold !== 1'b0) begin err_cnt++; $display("FAIL rst_ex_hold got %b want 0", bus.ex_hold); end
    vec_cnt++; if (bus.load_use_stall !== 1'b0) begin err_cnt++; $display("FAIL rst_stall got %b want 0", bus.load_use_stall); end
    vec_cnt++; if (bus.protocol_err !== 1'b0) begin err_cnt++; $display("FAIL rst_perr got %b want 0", bus.protocol_err); end
    resetn = 1'b1;
  endtask

  task automatic test_alu_chain;
    tick();
    drive_ex(1'b0, 6'd3, 32'h11);
    #1;
    vec_cnt++; if (bus.fwd_ex_en !== 1'b1) begin err_cnt++; $display("FAIL alu_ex_en got %b want 1", bus.fwd_ex_en); end
    vec_cnt++; if (bus.fwd_ex_data !== 32'h11) begin err_cnt++; $display("FAIL alu_ex_data got %h want 11", bus.fwd_ex_data); end
    tick();
    idle_inputs();
    #1;
    vec_cnt++; if (bus.fwd_mem_en !== 1'b1) begin err_cnt++; $display("FAIL alu_mem_en got %b want 1", bus.fwd_mem_en); end
    vec_cnt++; if (bus.fwd_mem_addr !== 6'd3) begin err_cnt++; $display("FAIL alu_mem_addr got %0d want 3", bus.fwd_mem_addr); end
    vec_cnt++; if (bus.fwd_mem_data !== 32'h11) begin err_cnt++; $display("FAIL alu_mem_data got %h want 11", bus.fwd_mem_data); end
    vec_cnt++; if (bus.rf_we !== 1'b0) begin err_cnt++; $display("FAIL alu_rf_we_early got %b want 0", bus.rf_we); end
    tick();
    #1;
    vec_cnt++; if (bus.rf_we !== 1'b1) begin err_cnt++; $display("FAIL alu_rf_we got %b want 1", bus.rf_we); end
    vec_cnt++; if (bus.rf_waddr !== 6'd3) begin err_cnt++; $display("FAIL alu_rf_waddr got %0d want 3", bus.rf_waddr); end
    vec_cnt++; if (bus.rf_wdata !== 32'h11) begin err_cnt++; $display("FAIL alu_rf_wdata got %h want 11", bus.rf_wdata); end
    vec_cnt++; if (bus.fwd_mem_en !== 1'b0) begin err_cnt++; $display("FAIL alu_mem_bubble got %b want 0", bus.fwd_mem_en); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [3];
    vals[0] = 32'h0000_0001; vals[1] = 32'h0000_0002; vals[2] = 32'h0000_0003;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 3) drive_ex(1'b0, 6'(i + 1), vals[i]);
      else idle_inputs();
      #1;
      if (i >= 1 && i <= 3) begin
        vec_cnt++; if (bus.fwd_mem_en !== 1'b1 || bus.fwd_mem_addr !== 6'(i) || bus.fwd_mem_data !== vals[i-1]) begin
          err_cnt++; $display("FAIL b2b_mem cyc%0d got en=%b a=%0d d=%h want en=1 a=%0d d=%h", i, bus.fwd_mem_en, bus.fwd_mem_addr, bus.fwd_mem_data, i, vals[i-1]);
        end
      end
      if (i >= 2) begin
        vec_cnt++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 6'(i - 1) || bus.rf_wdata !== vals[i-2]) begin
          err_cnt++; $display("FAIL b2b_rf cyc%0d got we=%b a=%0d d=%h want we=1 a=%0d d=%h", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, i - 1, vals[i-2]);
        end
      end
    end
  endtask

  task automatic test_load_use;
    tick();
    drive_ex(1'b1, 6'd5, 32'h99);
    bus.id_rs_addr = 6'd5;
    #1;
    vec_cnt++; if (bus.load_use_stall !== 1'b1) begin err_cnt++; $display("FAIL lu_stall_ex got %b want 1", bus.load_use_stall); end
    vec_cnt++; if (bus.fwd_ex_en !== 1'b0) begin err_cnt++; $display("FAIL lu_ex_en got %b want 0", bus.fwd_ex_en); end
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.ex_valid = 1'b0;
      #1;
      vec_cnt++; if (bus.ex_hold !== 1'b1 || bus.load_use_stall !== 1'b1 || bus.fwd_mem_en !== 1'b0) begin
        err_cnt++; $display("FAIL lu_wait cyc%0d got hold=%b stall=%b mem_en=%b want 1 1 0", i, bus.ex_hold, bus.load_use_stall, bus.fwd_mem_en);
      end
    end
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD;
    tick();
    bus.mem_rvalid = 1'b0;
    #1;
    vec_cnt++; if (bus.fwd_mem_en !== 1'b1 || bus.fwd_mem_data !== 32'hDEAD) begin err_cnt++; $display("FAIL lu_mem_fwd got en=%b d=%h want 1 dead", bus.fwd_mem_en, bus.fwd_mem_data); end
    vec_cnt++; if (bus.load_use_stall !== 1'b0 || bus.ex_hold !== 1'b0) begin err_cnt++; $display("FAIL lu_release got stall=%b hold=%b want 0 0", bus.load_use_stall, bus.ex_hold); end
    tick();
    #1;
    vec_cnt++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 6'd5 || bus.rf_wdata !== 32'hDEAD) begin err_cnt++; $display("FAIL lu_rf got we=%b a=%0d d=%h want 1 5 dead", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    idle_inputs();
  endtask

  task automatic test_zero_reg;
    tick();
    drive_ex(1'b0, 6'd0, 32'hFFFF);
    #1;
    vec_cnt++; if (bus.fwd_ex_en !== 1'b0) begin err_cnt++; $display("FAIL z_ex_en got %b want 0", bus.fwd_ex_en); end
    tick();
    drive_ex(1'b1, 6'd0, 32'h0);
    #1;
    vec_cnt++; if (bus.fwd_mem_en !== 1'b0) begin err_cnt++; $display("FAIL z_mem_en got %b want 0", bus.fwd_mem_en); end
    vec_cnt++; if (bus.load_use_stall !== 1'b0) begin err_cnt++; $display("FAIL z_stall_ex got %b want 0", bus.load_use_stall); end
    tick();
    bus.ex_valid   = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF;
    #1;
    vec_cnt++; if (bus.rf_we !== 1'b0) begin err_cnt++; $display("FAIL z_rf_alu got %b want 0", bus.rf_we); end
    vec_cnt++; if (bus.ex_hold !== 1'b1 || bus.load_use_stall !== 1'b0) begin err_cnt++; $display("FAIL z_wait got hold=%b stall=%b want 1 0", bus.ex_hold, bus.load_use_stall); end
    tick();
    bus.mem_rvalid = 1'b0;
    #1;
    vec_cnt++; if (bus.fwd_mem_en !== 1'b0) begin err_cnt++; $display("FAIL z_mem_load got %b want 0", bus.fwd_mem_en); end
    tick();
    #1;
    vec_cnt++; if (bus.rf_we !== 1'b0) begin err_cnt++; $display("FAIL z_rf_load got %b want 0", bus.rf_we); end
    idle_inputs();
  endtask

  task automatic test_flush_wait;
    tick();
    drive_ex(1'b1, 6'd7, 32'h0);
    tick();
    bus.ex_valid = 1'b0;
    bus.flush    = 1'b1;
    #1;
    vec_cnt++; if (bus.ex_hold !== 1'b1) begin err_cnt++; $display("FAIL fw_hold_wait got %b want 1", bus.ex_hold); end
    tick();
    bus.flush      = 1'b0;
    bus.id_rs_addr = 6'd7;
    #1;
    vec_cnt++; if (bus.ex_hold !== 1'b1 || bus.fwd_mem_en !== 1'b0 || bus.load_use_stall !== 1'b0) begin
      err_cnt++; $display("FAIL fw_drain got hold=%b mem_en=%b stall=%b want 1 0 0", bus.ex_hold, bus.fwd_mem_en, bus.load_use_stall);
    end
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234;
    #1;
    vec_cnt++; if (bus.ex_hold !== 1'b1) begin err_cnt++; $display("FAIL fw_hold_rvalid got %b want 1", bus.ex_hold); end
    tick();
    bus.mem_rvalid = 1'b0;
    #1;
    vec_cnt++; if (bus.ex_hold !== 1'b0 || bus.fwd_mem_en !== 1'b0 || bus.protocol_err !== 1'b0) begin
      err_cnt++; $display("FAIL fw_after got hold=%b mem_en=%b perr=%b want 0 0 0", bus.ex_hold, bus.fwd_mem_en, bus.protocol_err);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      vec_cnt++; if (bus.rf_we !== 1'b0) begin err_cnt++; $display("FAIL fw_no_rf cyc%0d got %b want 0", i, bus.rf_we); end
    end
    idle_inputs();
  endtask

  task automatic test_flush_rvalid;
    tick();
    drive_ex(1'b1, 6'd9, 32'h0);
    tick();
    bus.ex_valid   = 1'b0;
    bus.flush      = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBEEF;
    tick();
    bus.flush      = 1'b0;
    bus.mem_rvalid = 1'b0;
    drive_ex(1'b0, 6'd10, 32'h55);
    #1;
    vec_cnt++; if (bus.ex_hold !== 1'b0 || bus.fwd_mem_en !== 1'b0) begin err_cnt++; $display("FAIL fr_idle got hold=%b mem_en=%b want 0 0", bus.ex_hold, bus.fwd_mem_en); end
    tick();
    bus.ex_valid = 1'b0;
    #1;
    vec_cnt++; if (bus.fwd_mem_en !== 1'b1 || bus.fwd_mem_addr !== 6'd10 || bus.fwd_mem_data !== 32'h55) begin
      err_cnt++; $display("FAIL fr_alu_mem got en=%b a=%0d d=%h want 1 10 55", bus.fwd_mem_en, bus.fwd_mem_addr, bus.fwd_mem_data);
    end
    vec_cnt++; if (bus.rf_we !== 1'b0) begin err_cnt++; $display("FAIL fr_no_rf got %b want 0", bus.rf_we); end
    tick();
    #1;
    vec_cnt++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 6'd10 || bus.rf_wdata !== 32'h55) begin
      err_cnt++; $display("FAIL fr_rf got we=%b a=%0d d=%h want 1 10 55", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    idle_inputs();
  endtask

  task automatic test_protocol_err;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hAAAA;
    tick();
    bus.mem_rvalid = 1'b0;
    #1;
    vec_cnt++; if (bus.protocol_err !== 1'b1 || bus.ex_hold !== 1'b0) begin err_cnt++; $display("FAIL perr got perr=%b hold=%b want 1 0", bus.protocol_err, bus.ex_hold); end
  endtask

  task automatic test_reset_wait;
    tick();
    drive_ex(1'b1, 6'd4, 32'h0);
    bus.id_rs_addr = 6'd4;
    tick();
    bus.ex_valid = 1'b0;
    resetn       = 1'b0;
    #1;
    vec_cnt++; if (bus.ex_hold !== 1'b1) begin err_cnt++; $display("FAIL rw_pre got %b want 1", bus.ex_hold); end
    tick();
    #1;
    vec_cnt++; if (bus.ex_hold !== 1'b0 || bus.load_use_stall !== 1'b0 || bus.fwd_mem_en !== 1'b0 || bus.fwd_mem_addr !== 6'd0) begin
      err_cnt++; $display("FAIL rw_state got hold=%b stall=%b mem_en=%b a=%0d want 0 0 0 0", bus.ex_hold, bus.load_use_stall, bus.fwd_mem_en, bus.fwd_mem_addr);
    end
    vec_cnt++; if (bus.rf_we !== 1'b0 || bus.protocol_err !== 1'b0) begin err_cnt++; $display("FAIL rw_rf got we=%b perr=%b want 0 0", bus.rf_we, bus.protocol_err); end
    resetn = 1'b1;
    drive_ex(1'b0, 6'd6, 32'h77);
    tick();
    bus.ex_valid = 1'b0;
    #1;
    vec_cnt++; if (bus.fwd_mem_en !== 1'b1 || bus.fwd_mem_addr !== 6'd6 || bus.fwd_mem_data !== 32'h77) begin
      err_cnt++; $display("FAIL rw_accept got en=%b a=%0d d=%h want 1 6 77", bus.fwd_mem_en, bus.fwd_mem_addr, bus.fwd_mem_data);
    end
    tick();
    #1;
    vec_cnt++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 6'd6) begin err_cnt++; $display("FAIL rw_rf_commit got we=%b a=%0d want 1 6", bus.rf_we, bus.rf_waddr); end
    idle_inputs();
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    resetn  = 1'b0;
    idle_inputs();
    test_reset();
    test_alu_chain();
    test_back_to_back();
    test_load_use();
    test_zero_reg();
    test_flush_wait();
    test_flush_rvalid();
    test_protocol_err();
    test_reset_wait();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
